serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
Bit-serial to parallel word receiver, the receive end of the serial bit link driven by the mux-based bit selector. It collects one bit per accepted beat into a WIDTH-bit word, framed by a start marker on bit 0. It presents the completed word on a valid/ready handshake to the datapath (register file load or bus capture) and flags framing faults.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 0, bit order: 0 = first received bit lands in word[0]; 1 = first received bit lands in word[WIDTH-1].

Ports:
clk  input  1  single clock, all state updates on posedge.
reset  input  1  synchronous, active-high reset.
ser_valid  input  1  serial beat present this cycle.
ser_bit  input  1  serial data bit.
ser_start  input  1  marks the beat carrying bit 0 of a frame; qualified by ser_valid.
ser_ready  output  1  receiver can accept a beat; beat accepted = ser_valid & ser_ready.
word  output  WIDTH  assembled word; stable while word_valid=1.
word_valid  output  1  completed word available.
word_ready  input  1  consumer accepts word; transfer = word_valid & word_ready.
frame_err  output  1  one-cycle pulse on a framing fault.
parity_err  output  1  parity result for the presented word; see Optional Feature.

Behaviour:
- Reset (reset=1 at posedge) overrides all other inputs. Resulting state: IDLE, bit counter=0, word=0, word_valid=0, frame_err=0, parity_err=0. ser_ready=1.
- Reset mid-frame or mid-HOLD discards the partial or held word. There is no output for the discarded word.
- States: IDLE, SHIFT, (PAR with PARITY_EN), HOLD. ser_ready = 1 in IDLE, SHIFT and PAR; ser_ready = 0 in HOLD.
- Bit placement: the k-th accepted bit of a frame (k = 0..WIDTH-1) is written to word[k], or to word[WIDTH-1-k] when MSB_FIRST=1.
- IDLE:
  - Accepted beat with ser_start=1: clear word, write bit 0, set counter=1, go to SHIFT.
  - Accepted beat with ser_start=0: bit dropped, frame_err=1 for the next cycle, stay in IDLE.
- SHIFT:
  - Accepted beat with ser_start=0: write bit at counter, counter+1.
  - When the beat with k = WIDTH-1 is accepted, go to HOLD (or PAR when PARITY_EN is defined).
  - ser_valid=0 cycles (gaps) are ignored; there is no timeout.
- Restart in SHIFT or PAR: an accepted beat with ser_start=1 discards the partial word. It clears word, writes the new bit 0, sets counter=1, enters SHIFT, and pulses frame_err for one cycle.
- HOLD:
  - word_valid=1, word held constant, all serial beats ignored.
  - On the transfer cycle (word_valid & word_ready), the next state is IDLE and word_valid=0.
  - word keeps its value until the next start beat.
- Latency: word_valid rises on the cycle after the final bit (or parity beat) is accepted.
- Minimum frame period: WIDTH (+1 with parity) beat cycles, plus 1 HOLD cycle.
- frame_err is registered, one cycle wide per fault. Faults on back-to-back cycles give consecutive pulses.
- The counter is sized ceil(log2(WIDTH+1)). It never exceeds WIDTH and never wraps.

Optional Feature:
Macro: SERIAL_DESERIALIZER_PARITY_EN.
- Defined:
  - After WIDTH data bits, state PAR accepts exactly one more beat as the even-parity bit.
  - parity_err is registered at HOLD entry as XOR(word bits, parity bit). It is 1 when the XOR is odd.
  - parity_err is held through HOLD and cleared on transfer or reset.
  - ser_start in PAR is a restart, as above.
- Undefined: no PAR state, frame is WIDTH beats, and parity_err is constant 0. The port is always present.

Test Plan:
- Reset: assert reset 2 cycles with ser_valid=1, ser_start=1 -> word=0x00, word_valid=0, ser_ready=1, frame_err=0. No frame is started.
- WIDTH=8, LSB-first: send 0xA5 as bits 1,0,1,0,0,1,0,1 on consecutive cycles, start on the first, word_ready=1 -> word_valid=1 for exactly one cycle, starting the cycle after beat 8. word=0xA5, then IDLE.
- Backpressure: 0xA5 received, word_ready=0 for 5 cycles while ser_valid=1 with random bits -> word_valid stays 1, ser_ready=0, word stays 0xA5. Raise word_ready -> single transfer, ser_ready=1 next cycle.
- Restart and stray beat: beat without start in IDLE -> frame_err single pulse, still IDLE. Then start + 3 bits, then new start + 0x3C -> second frame_err pulse, word=0x3C. Gaps of 2 idle cycles inserted mid-frame give the same result.
- Reset mid-frame after 4 bits, then frame 0xFF -> word=0xFF, no frame_err. Repeat with MSB_FIRST=1 sending bits 1,0,1,0,0,1,0,1 -> word=0xA5.
- PARITY_EN defined: 0x07 followed by parity bit 1 -> parity_err=0. 0x07 followed by parity bit 0 -> parity_err=1. In both cases word_valid rises the cycle after beat 9.

Source files
------------

// File: rtl/serial_deserializer.sv
// Bit-serial to parallel word receiver with start-marker framing and a valid/ready word output.
// Optional even-parity beat after the data bits is enabled by defining SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_valid,
    input  logic             ser_bit,
    input  logic             ser_start,
    output logic             ser_ready,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a beat moves when ser_valid & ser_ready; a word moves when word_valid & word_ready.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd3;
`endif

    localparam int            FIRST_POS = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [CW-1:0] LAST_K    = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             frame_err_q, frame_err_d;
    logic [CW-1:0]    bit_pos;
    logic             accept;

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic parity_err_q, parity_err_d;
`endif

    assign ser_ready   = (state_q != S_HOLD);
    assign accept      = ser_valid & ser_ready;
    assign bit_pos     = MSB_FIRST ? (LAST_K - cnt_q) : cnt_q;
    assign word        = word_q;
    assign word_valid  = (state_q == S_HOLD);
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        frame_err_d = 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        // A start beat always opens a fresh frame; outside IDLE it also abandons a partial one.
        if (accept && ser_start) begin
            word_d            = '0;
            word_d[FIRST_POS] = ser_bit;
            cnt_d             = CW'(1);
            state_d           = S_SHIFT;
            frame_err_d       = (state_q != S_IDLE);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        frame_err_d = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (accept) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (CW'(i) == bit_pos) begin
                                word_d[i] = ser_bit;
                            end
                        end
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_K) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                            state_d = S_PAR;
`else
                            state_d = S_HOLD;
`endif
                        end
                    end
                end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                S_PAR: begin
                    if (accept) begin
                        parity_err_d = ^{word_q, ser_bit};
                        state_d      = S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (word_ready) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                        parity_err_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            frame_err_q <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            frame_err_q <= frame_err_d;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: directed vector table, hand-written corner sequences and
// randomized beats checked against a bit-queue reference model, on LSB-first and MSB-first instances.
module tb_serial_deserializer;

    localparam int W = 8;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ser_valid = 1'b0;
    logic ser_bit = 1'b0;
    logic ser_start = 1'b0;
    logic word_ready = 1'b0;

    logic         ready_l, valid_l, ferr_l, perr_l;
    logic [W-1:0] word_l;
    logic [1:0]   dbg_l;
    logic         ready_m, valid_m, ferr_m, perr_m;
    logic [W-1:0] word_m;
    logic [1:0]   dbg_m;

    int checks = 0;
    int failures = 0;
    int ferr_seen = 0;

    // Reference model state: bits of the frame in progress, in arrival order.
    bit           m_bits[$];
    bit           m_hold = 1'b0;
    bit           m_ferr = 1'b0;
    bit           m_perr = 1'b0;
    logic [W-1:0] m_word_l = '0;
    logic [W-1:0] m_word_m = '0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_bit(ser_bit),
        .ser_start(ser_start), .ser_ready(ready_l), .word(word_l), .word_valid(valid_l),
        .word_ready(word_ready), .frame_err(ferr_l), .parity_err(perr_l), .dbg_state_o(dbg_l)
    );

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_bit(ser_bit),
        .ser_start(ser_start), .ser_ready(ready_m), .word(word_m), .word_valid(valid_m),
        .word_ready(word_ready), .frame_err(ferr_m), .parity_err(perr_m), .dbg_state_o(dbg_m)
    );

    typedef struct {
        bit           rst, v, b, s, wr;
        bit           e_valid, e_ready, e_ferr;
        logic [W-1:0] e_word_l, e_word_m;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input bit b, input bit s, input bit wr);
        int n;
        bit p;
        m_ferr = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_hold   = 1'b0;
            m_perr   = 1'b0;
            m_word_l = '0;
            m_word_m = '0;
        end else if (m_hold) begin
            if (wr) begin
                m_hold = 1'b0;
                m_perr = 1'b0;
            end
        end else if (v) begin
            if (s) begin
                m_ferr = (m_bits.size() != 0);
                m_bits.delete();
                m_bits.push_back(b);
            end else if (m_bits.size() == 0) begin
                m_ferr = 1'b1;
            end else begin
                m_bits.push_back(b);
            end
            if (m_bits.size() > 0) begin
                n = (m_bits.size() < W) ? m_bits.size() : W;
                m_word_l = '0;
                m_word_m = '0;
                for (int k = 0; k < n; k++) begin
                    m_word_l[k]     = m_bits[k];
                    m_word_m[W-1-k] = m_bits[k];
                end
            end
            if (m_bits.size() == FRAME_LEN) begin
                p = 1'b0;
                foreach (m_bits[k]) p = p ^ m_bits[k];
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                m_perr = p;
`endif
                m_hold = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit b, input bit s, input bit wr);
        reset = rst; ser_valid = v; ser_bit = b; ser_start = s; word_ready = wr;
        @(posedge clk);
        model_step(rst, v, b, s, wr);
        #1;
        if (ferr_l === 1'b1) ferr_seen++;
        chk("lsb_word", word_l, m_word_l);
        chk("lsb_valid", valid_l, m_hold);
        chk("lsb_ready", ready_l, !m_hold);
        chk("lsb_frame_err", ferr_l, m_ferr);
        chk("lsb_parity_err", perr_l, m_perr);
        chk("msb_word", word_m, m_word_m);
        chk("msb_valid", valid_m, m_hold);
        chk("msb_ready", ready_m, !m_hold);
        chk("msb_frame_err", ferr_m, m_ferr);
        chk("msb_parity_err", perr_m, m_perr);
    endtask

    // Sends val with val[k] as the k-th beat, optional idle gap mid-frame, plus even parity when enabled.
    task automatic send_frame(input logic [W-1:0] val, input int gap, input bit wr);
        for (int k = 0; k < W; k++) begin
            step(1'b0, 1'b1, val[k], k == 0, wr);
            if (k == W / 2) begin
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, wr);
            end
        end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        step(1'b0, 1'b1, ^val, 1'b0, wr);
`endif
    endtask

    function automatic vec_t mk(input bit rst, input bit v, input bit b, input bit s, input bit wr,
                                input bit ev, input bit er, input bit ef,
                                input logic [W-1:0] el, input logic [W-1:0] em);
        vec_t t;
        t.rst = rst; t.v = v; t.b = b; t.s = s; t.wr = wr;
        t.e_valid = ev; t.e_ready = er; t.e_ferr = ef; t.e_word_l = el; t.e_word_m = em;
        return t;
    endfunction

    initial begin
        vec_t tbl[12];
        logic [W-1:0] pat;

        // Reset with start beats present, then 0xA5 as 1,0,1,0,0,1,0,1 with word_ready high.
        tbl[0]  = mk(1, 1, 1, 1, 1, 0, 1, 0, 8'h00, 8'h00);
        tbl[1]  = mk(1, 1, 1, 1, 1, 0, 1, 0, 8'h00, 8'h00);
        tbl[2]  = mk(0, 1, 1, 1, 1, 0, 1, 0, 8'h01, 8'h80);
        tbl[3]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 8'h01, 8'h80);
        tbl[4]  = mk(0, 1, 1, 0, 1, 0, 1, 0, 8'h05, 8'hA0);
        tbl[5]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 8'h05, 8'hA0);
        tbl[6]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 8'h05, 8'hA0);
        tbl[7]  = mk(0, 1, 1, 0, 1, 0, 1, 0, 8'h25, 8'hA4);
        tbl[8]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 8'h25, 8'hA4);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        tbl[9]  = mk(0, 1, 1, 0, 1, 0, 1, 0, 8'hA5, 8'hA5);
        tbl[10] = mk(0, 1, 0, 0, 1, 1, 0, 0, 8'hA5, 8'hA5);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 1, 0, 8'hA5, 8'hA5);
`else
        tbl[9]  = mk(0, 1, 1, 0, 1, 1, 0, 0, 8'hA5, 8'hA5);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 1, 0, 8'hA5, 8'hA5);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'hA5, 8'hA5);
`endif
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].wr);
            chk($sformatf("tbl%0d_valid", i), valid_l, tbl[i].e_valid);
            chk($sformatf("tbl%0d_ready", i), ready_l, tbl[i].e_ready);
            chk($sformatf("tbl%0d_ferr", i), ferr_l, tbl[i].e_ferr);
            chk($sformatf("tbl%0d_word_lsb", i), word_l, tbl[i].e_word_l);
            chk($sformatf("tbl%0d_word_msb", i), word_m, tbl[i].e_word_m);
        end

        // Backpressure: word held while beats keep arriving.
        send_frame(8'hA5, 0, 1'b0);
        chk("bp_valid0", valid_l, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            chk("bp_valid", valid_l, 1'b1);
            chk("bp_ready", ready_l, 1'b0);
            chk("bp_word", word_l, 8'hA5);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_xfer_valid", valid_l, 1'b0);
        chk("bp_xfer_ready", ready_l, 1'b1);
        chk("bp_word_kept", word_l, 8'hA5);

        // Stray beat then restart, without and with mid-frame gaps.
        for (int gap = 0; gap <= 2; gap += 2) begin
            ferr_seen = 0;
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            chk("stray_ferr", ferr_l, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("stray_ferr_end", ferr_l, 1'b0);
            chk("stray_idle_ready", ready_l, 1'b1);
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            send_frame(8'h3C, gap, 1'b1);
            chk("restart_valid", valid_l, 1'b1);
            chk("restart_word", word_l, 8'h3C);
            chk("restart_ferr_pulses", ferr_seen, 2);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Reset mid-frame after 4 bits discards it cleanly.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("midreset_word", word_l, 8'h00);
        ferr_seen = 0;
        send_frame(8'hFF, 0, 1'b1);
        chk("ff_word_lsb", word_l, 8'hFF);
        chk("ff_word_msb", word_m, 8'hFF);
        chk("ff_no_ferr", ferr_seen, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 0, 1'b1);
        chk("msb_a5", word_m, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pat = 8'h1E;
        send_frame(pat, 1, 1'b1);
        chk("msb_reversed", word_m, 8'h78);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
        for (int pb = 1; pb >= 0; pb--) begin
            pat = 8'h07;
            for (int k = 0; k < W; k++) step(1'b0, 1'b1, pat[k], k == 0, 1'b0);
            chk("par_not_yet_valid", valid_l, 1'b0);
            step(1'b0, 1'b1, 1'(pb), 1'b0, 1'b0);
            chk("par_valid", valid_l, 1'b1);
            chk("par_err", perr_l, (pb == 1) ? 1'b0 : 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("par_err_cleared", perr_l, 1'b0);
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
